cpu_clk_ctrl: RTL

- Sequences the pipeline CPU's execution rate on the FPGA board.
- Replaces free-running clock division with a single-cycle clock-enable (cpu_ce) that runs at a programmable rate.
- Also supports single-stepping on a debounced push-button, holding the core halted, and stopping on a CPU halt/breakpoint request.
- Sits between board inputs (switches, button) and the CPU's pipeline-register enables.

---
 rtl/cpu_clk_ctrl.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/cpu_clk_ctrl.sv
// cpu_clk_ctrl: clock-enable sequencer for the pipeline CPU.
// Generates a single-cycle cpu_ce at a programmable RUN rate, single-steps on a
// debounced push-button, and stops sticky on a CPU halt/breakpoint request.
// Optional macro CPU_CLK_OUT_EN builds a toggled level clock (cpu_clk) from cpu_ce.
module cpu_clk_ctrl #(
  parameter int unsigned DIV_W           = 24,
  parameter int unsigned DEBOUNCE_CYCLES = 65535,
  parameter int unsigned CNT_W           = 32
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] div_val,
  input  logic             step_btn,
  input  logic             halt_req,
  output logic             cpu_ce,
  output logic             cpu_clk,
  output logic             running,
  output logic             brk,
  output logic [CNT_W-1:0] ce_count
);

  localparam int unsigned DEB_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_STEP_ARM,
    S_STEP_REL,
    S_BRK
  } state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   cnt_q, cnt_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [DEB_W-1:0]   deb_q, deb_d;
  logic [1:0]         sync_q, sync_d;
  logic               ce_q, ce_d;
  logic [CNT_W-1:0]   ce_count_q, ce_count_d;
  logic               running_q, running_d;
  logic               brk_q, brk_d;
  logic               btn_s;

  assign btn_s = sync_q[1];

  // Two-stage synchronizer input for the raw push-button.
  always_comb sync_d = {sync_q[0], step_btn};

  // Next-state, period counter, debounce counter and pulse generation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    deb_d   = '0;
    ce_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (mode[1]) begin
          state_d = S_RUN;
          div_d   = div_val;
        end else if (mode == 2'b01) begin
          state_d = S_STEP_ARM;
        end
      end
      S_RUN: begin
        // halt_req is checked first so it wins over a terminal count.
        if (halt_req) begin
          state_d = S_BRK;
          cnt_d   = '0;
        end else if (!mode[1]) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == div_q) begin
          ce_d  = 1'b1;
          cnt_d = '0;
          div_d = div_val;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      S_STEP_ARM: begin
        if (mode != 2'b01) begin
          state_d = S_IDLE;
        end else if (halt_req) begin
          state_d = S_BRK;
        end else if (btn_s) begin
          if (deb_q == DEB_LAST) begin
            ce_d    = 1'b1;
            state_d = S_STEP_REL;
          end else begin
            deb_d = deb_q + DEB_W'(1);
          end
        end
      end
      S_STEP_REL: begin
        if (mode != 2'b01) begin
          state_d = S_IDLE;
        end else if (!btn_s) begin
          if (deb_q == DEB_LAST) begin
            state_d = S_STEP_ARM;
          end else begin
            deb_d = deb_q + DEB_W'(1);
          end
        end
      end
      S_BRK: begin
        if (mode == 2'b00) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered status outputs and the retired-enable counter.
  always_comb begin
    ce_count_d = ce_count_q + CNT_W'(ce_d);
    running_d  = (state_d == S_RUN);
    brk_d      = (state_d == S_BRK);
  end

  // State and output registers.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      div_q      <= '0;
      deb_q      <= '0;
      sync_q     <= '0;
      ce_q       <= 1'b0;
      ce_count_q <= '0;
      running_q  <= 1'b0;
      brk_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      deb_q      <= deb_d;
      sync_q     <= sync_d;
      ce_q       <= ce_d;
      ce_count_q <= ce_count_d;
      running_q  <= running_d;
      brk_q      <= brk_d;
    end
  end

  assign cpu_ce   = ce_q;
  assign ce_count = ce_count_q;
  assign running  = running_q;
  assign brk      = brk_q;

`ifdef CPU_CLK_OUT_EN
  logic cpu_clk_q, cpu_clk_d;

  // Level clock toggles one cycle after each enable pulse.
  always_comb cpu_clk_d = cpu_clk_q ^ ce_q;

  // Toggle flop for the legacy divided clock.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) cpu_clk_q <= 1'b0;
    else       cpu_clk_q <= cpu_clk_d;
  end

  assign cpu_clk = cpu_clk_q;
`else
  assign cpu_clk = 1'b0;
`endif

endmodule
